// File: rtl/mux_l2_pkg.sv
// Shared definitions for the L2 conditional lane serializer: state encoding,
// default lane width and valid-mask bit positions.
package mux_l2_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MASK_LANE0 = 0;
  localparam int MASK_LANE1 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND0 = 2'b01,
    SEND1 = 2'b10
  } state_e;

endpackage

// File: rtl/mux_l2_pair_buf.sv
// Two-entry byte holding register with a per-lane valid mask; load captures a
// whole lane pair, clear drops the mask so nothing stays pending.
module mux_l2_pair_buf
  import mux_l2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_l_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [1:0]        mask_i,
  input  logic              sel_i,
  output logic [DATA_W-1:0] byte_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] d0_q;
  logic [DATA_W-1:0] d1_q;
  logic [1:0]        mask_q;

  // Pair storage: load wins over clear.
  always_ff @(posedge clk_i or negedge reset_l_i) begin
    if (!reset_l_i) begin
      d0_q   <= {DATA_W{1'b0}};
      d1_q   <= {DATA_W{1'b0}};
      mask_q <= 2'b00;
    end else if (load_i) begin
      d0_q   <= d0_i;
      d1_q   <= d1_i;
      mask_q <= mask_i;
    end else if (clear_i) begin
      mask_q <= 2'b00;
    end
  end

  assign byte_o  = sel_i ? d1_q : d0_q;
  assign valid_o = mask_q[sel_i];

endmodule

// File: rtl/mux2a1_serial_condl2.sv
// L2 lane serializer: emits lane 0 then lane 1 of each accepted pair, skipping
// invalid lanes. Define MUX_L2_PARITY_EN to add the registered parity_out port.
module mux2a1_serial_condl2
  import mux_l2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid0,
  input  logic              valid1,
  input  logic [DATA_W-1:0] data_in0_muxL2,
  input  logic [DATA_W-1:0] data_in1_muxL2,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              validout,
`ifdef MUX_L2_PARITY_EN
  output logic              parity_out,
`endif
  output logic [DATA_W-1:0] dataout_muxL2
);

  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction

  state_e            state_q;
  logic              validout_q;
  logic [DATA_W-1:0] dataout_q;

  state_e            first_state_s;
  logic [DATA_W-1:0] first_byte_s;
  logic              last_s;
  logic              accept_s;
  logic              buf_clear_s;
  logic              dout_load_s;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] hi_byte_s;
  logic              hi_valid_s;

  mux_l2_pair_buf #(.DATA_W(DATA_W)) u_pair_buf (
    .clk_i     (clk),
    .reset_l_i (reset_L),
    .load_i    (accept_s),
    .clear_i   (buf_clear_s),
    .d0_i      (data_in0_muxL2),
    .d1_i      (data_in1_muxL2),
    .mask_i    ({valid1, valid0}),
    .sel_i     (1'(MASK_LANE1)),
    .byte_o    (hi_byte_s),
    .valid_o   (hi_valid_s)
  );

  // Handshake and next-output selection; a new pair's first byte bypasses the buffer.
  always_comb begin
    first_state_s = SEND1;
    first_byte_s  = data_in1_muxL2;
    if (valid0) begin
      first_state_s = SEND0;
      first_byte_s  = data_in0_muxL2;
    end else begin
      first_state_s = SEND1;
      first_byte_s  = data_in1_muxL2;
    end
    last_s      = (state_q == SEND1) | ((state_q == SEND0) & ~hi_valid_s);
    in_ready    = (state_q == IDLE) | (last_s & out_ready);
    accept_s    = in_ready & (valid0 | valid1);
    buf_clear_s = last_s & out_ready & ~accept_s;
    dout_load_s = accept_s | ((state_q == SEND0) & out_ready & hi_valid_s);
    dout_d      = accept_s ? first_byte_s : hi_byte_s;
  end

  // Serializer FSM with registered validout/dataout.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      validout_q <= 1'b0;
      dataout_q  <= {DATA_W{1'b0}};
    end else begin
      if (dout_load_s) begin
        dataout_q <= dout_d;
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q    <= first_state_s;
            validout_q <= 1'b1;
          end else begin
            validout_q <= 1'b0;
          end
        end
        SEND0, SEND1: begin
          if (out_ready) begin
            if ((state_q == SEND0) && hi_valid_s) begin
              state_q    <= SEND1;
              validout_q <= 1'b1;
            end else if (accept_s) begin
              state_q    <= first_state_s;
              validout_q <= 1'b1;
            end else begin
              state_q    <= IDLE;
              validout_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          validout_q <= 1'b0;
        end
      endcase
    end
  end

  assign validout      = validout_q;
  assign dataout_muxL2 = dataout_q;

`ifdef MUX_L2_PARITY_EN
  logic parity_q;

  // Parity tracks dataout on exactly the edges dataout is loaded.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      parity_q <= 1'b0;
    end else if (dout_load_s) begin
      parity_q <= even_parity(dout_d);
    end
  end

  assign parity_out = parity_q;
`endif

endmodule
